// File: rtl/exu_arb_pkg.sv
// Shared definitions for the two-requester add/sub arbiter: FSM encoding and requester ids.
package exu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic REQ0_ID = 1'b0;
  localparam logic REQ1_ID = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a tie goes to the requester not granted last.
module rr_arbiter_2
  import exu_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (&valid) grant = (last_grant == REQ1_ID) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/exu_add_arbiter.sv
// Arbitrates two requesters onto one shared add/sub datapath, one op in flight at a time.
// Optional per-requester grant counters are enabled by defining EXU_ADD_ARBITER_PERF_EN.
module exu_add_arbiter
  import exu_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req0_sub,
  input  logic              req1_sub,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_id,
`ifdef EXU_ADD_ARBITER_PERF_EN
  output logic              busy,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1
`else
  output logic              busy
`endif
);

  state_t            state;
  logic              last_grant;
  logic [1:0]        grant;
  logic              accept;
  logic [DATA_W-1:0] op_a, op_b, opnd_b, result;
  logic              op_sub, op_id;

  rr_arbiter_2 u_rr (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req0_ready = (state == IDLE) & grant[0];
  assign req1_ready = (state == IDLE) & grant[1];
  assign accept     = (state == IDLE) & (|grant);
  assign busy       = (state != IDLE);

  // Subtract as a + ~b + 1; carry out is dropped by the width.
  assign opnd_b = op_sub ? ~op_b : op_b;
  assign result = op_a + opnd_b + DATA_W'(op_sub);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= REQ0_ID;
      last_grant <= REQ1_ID;
      op_a       <= '0;
      op_b       <= '0;
      op_sub     <= 1'b0;
      op_id      <= REQ0_ID;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_a       <= grant[1] ? req1_a   : req0_a;
          op_b       <= grant[1] ? req1_b   : req0_b;
          op_sub     <= grant[1] ? req1_sub : req0_sub;
          op_id      <= grant[1];
          last_grant <= grant[1];
          state      <= EXEC;
        end
        EXEC: begin
          resp_data  <= result;
          resp_id    <= op_id;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXU_ADD_ARBITER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
    end else if (accept) begin
      if (grant[0]) perf_grant0 <= perf_grant0 + 32'd1;
      if (grant[1]) perf_grant1 <= perf_grant1 + 32'd1;
    end
  end
`endif

endmodule

// File: doc/exu_add_arbiter.md
EXU_ADD_ARBITER -- requirements
Module: exu_add_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester n's operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  DATA_W  operands.
REQ-007 SHALL have ports req0_sub / req1_sub  input  1  0 = a+b, 1 = a-b.
REQ-008 SHALL have port resp_valid  output  1  result available.
REQ-009 SHALL have port resp_ready  input  1  consumer takes result.
REQ-010 SHALL have port resp_data  output  DATA_W  result.
REQ-011 SHALL have port resp_id  output  1  index of the requester that owns resp_data.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE, one shared add/sub datapath.
REQ-014 In IDLE, reqN_ready SHALL be high for the granted requester only, combinationally from the valids; in EXEC/RESP both readies SHALL be low.
REQ-015 Handshake: reqN_valid & reqN_ready in cycle T SHALL latch a, b, sub, id and move to EXEC at T+1.
REQ-016 EXEC SHALL compute and register the result, so resp_valid rises at T+2 (fixed latency of 2 cycles).
REQ-017 Subtract SHALL be a + ~b + 1; all results modulo 2^DATA_W, carry/borrow discarded.
REQ-018 RESP SHALL hold resp_valid, resp_data and resp_id stable until resp_ready is high; that cycle SHALL return to IDLE.
REQ-019 No new request SHALL be accepted in the resp_ready cycle; the earliest next accept is the following cycle (back-to-back throughput of one operation per 3 cycles).
REQ-020 Arbitration: one requester valid -> grant it; both valid -> grant the one not granted last (round-robin); neither -> no grant.
REQ-021 last_grant SHALL update only on an accepted handshake.
REQ-022 Input changes while in EXEC/RESP SHALL not affect the in-flight operation.

Reset
REQ-023 rst_n low SHALL force, asynchronously: state IDLE, resp_valid 0, resp_data 0, resp_id 0, busy 0, last_grant 1 (req0 wins the first tie).
REQ-024 Reset mid-operation SHALL discard the in-flight operation; no response is produced for it.

Configuration
REQ-025 Macro EXU_ADD_ARBITER_PERF_EN defined SHALL add outputs perf_grant0 and perf_grant1 (output 32 each), counting accepted handshakes per requester, reset to 0, wrapping 0xFFFFFFFF -> 0.
REQ-026 Without EXU_ADD_ARBITER_PERF_EN those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-027 Shared package exu_arb_pkg SHALL hold the FSM state encoding (IDLE=2'b00, EXEC=2'b01, RESP=2'b10) and the requester-id constants.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter_2 (inputs 2 valids + last_grant, outputs one-hot grant).

Verification
REQ-029 Only req0 valid, a=5, b=3, sub=0, resp_ready=1 -> req0_ready at T, resp_valid at T+2, resp_data=8, resp_id=0.
REQ-030 Only req1 valid, a=3, b=5, sub=1 -> resp_data=0xFFFFFFFE, resp_id=1; a=0xFFFFFFFF, b=1, add -> 0x00000000.
REQ-031 Both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset; one accept per 3 cycles.
REQ-032 resp_ready held low 5 cycles in RESP -> resp_valid/data/id stable, both readies low, busy high throughout.
REQ-033 rst_n asserted during EXEC -> resp_valid stays 0, state IDLE, next accepted op returns its own correct result.
REQ-034 With EXU_ADD_ARBITER_PERF_EN, 3 req0 and 2 req1 accepts -> perf_grant0=3, perf_grant1=2; counters preset near 0xFFFFFFFF wrap to 0.
